// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16x16 register file and its one-hot write-select checker.
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned R0_IDX = 0;
    localparam int unsigned CNT_W  = $clog2(NREGS + 1);

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [NREGS-1:0]  reg_sel_t;

    // R0 is hardwired to zero: never written, never bypassed
    function automatic logic is_r0(input reg_addr_t a);
        return a == ADDR_W'(R0_IDX);
    endfunction

endpackage

// File: rtl/onehot_encode_16.sv
// Classifies a 16-bit write select as zero / one-hot / multi-hot and encodes the set bit's index.
module onehot_encode_16
    import regfile_pkg::*;
(
    input  reg_sel_t  i_sel,
    output reg_addr_t o_index_c,
    output logic      o_is_zero_c,
    output logic      o_is_onehot_c,
    output logic      o_is_multi_c
);

    logic [CNT_W-1:0] w_count;
    reg_addr_t        w_index;

    // Population count plus index of the set bit (meaningful only when exactly one is set)
    always_comb begin
        w_count = '0;
        w_index = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (i_sel[i]) begin
                w_count = w_count + CNT_W'(1);
                w_index = ADDR_W'(i);
            end
        end
    end

    assign o_index_c     = w_index;
    assign o_is_zero_c   = (w_count == CNT_W'(0));
    assign o_is_onehot_c = (w_count == CNT_W'(1));
    assign o_is_multi_c  = (w_count >  CNT_W'(1));

endmodule

// File: rtl/regfile_16x16_onehot.sv
// 16x16 register file with one-hot write select, two registered read ports and multi-hot fault flags.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_16x16_onehot
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_sel_t  we_onehot,
    input  reg_data_t wd,
    input  logic      rd_en,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    output reg_data_t rd1,
    output reg_data_t rd2,
    output logic      rd_valid,
    output logic      wr_err,
    output logic      wr_err_sticky
);

    reg_data_t r_regs [NREGS];
    reg_data_t r_rd1;
    reg_data_t r_rd2;
    logic      r_rd_valid;
    logic      r_wr_err;
    logic      r_wr_err_sticky;

    reg_addr_t w_wr_idx;
    logic      w_is_zero;
    logic      w_is_onehot;
    logic      w_is_multi;
    logic      w_wr_commit;
    reg_data_t w_rd1_next;
    reg_data_t w_rd2_next;

    onehot_encode_16 u_sel_enc (
        .i_sel         (we_onehot),
        .o_index_c     (w_wr_idx),
        .o_is_zero_c   (w_is_zero),
        .o_is_onehot_c (w_is_onehot),
        .o_is_multi_c  (w_is_multi)
    );

    // A write commits only for a clean one-hot select that does not target R0
    assign w_wr_commit = w_is_onehot & ~w_is_zero & ~is_r0(w_wr_idx);

    // Read-port data selection, with optional forwarding of the same-edge write
    always_comb begin
        w_rd1_next = r_regs[ra1];
        w_rd2_next = r_regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_commit && (ra1 == w_wr_idx)) begin
            w_rd1_next = wd;
        end
        if (w_wr_commit && (ra2 == w_wr_idx)) begin
            w_rd2_next = wd;
        end
`endif
        if (is_r0(ra1)) begin
            w_rd1_next = '0;
        end
        if (is_r0(ra2)) begin
            w_rd2_next = '0;
        end
    end

    // Register array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[w_wr_idx] <= wd;
        end
    end

    // Read stage and fault flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1           <= '0;
            r_rd2           <= '0;
            r_rd_valid      <= 1'b0;
            r_wr_err        <= 1'b0;
            r_wr_err_sticky <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_wr_err   <= w_is_multi;
            if (rd_en) begin
                r_rd1 <= w_rd1_next;
                r_rd2 <= w_rd2_next;
            end
            if (w_is_multi) begin
                r_wr_err_sticky <= 1'b1;
            end
        end
    end

    assign rd1           = r_rd1;
    assign rd2           = r_rd2;
    assign rd_valid      = r_rd_valid;
    assign wr_err        = r_wr_err;
    assign wr_err_sticky = r_wr_err_sticky;

endmodule

// File: doc/regfile_16x16_onehot.md
Name: regfile_16x16_onehot

Overview:
- 16-entry x 16-bit general-purpose register file for the 16-bit MIPS datapath.
- Sits directly downstream of the 4-to-16 write-address decoder and consumes its one-hot output as the write select.
- Provides two registered read ports for the operand-fetch stage.
- Validates the one-hot select and flags decoder faults instead of corrupting state.

Parameters:
- DATA_W, 16, register and write-data width.
- NREGS, 16, number of registers; equals the one-hot select width.
- ADDR_W, 4, read-address width; log2(NREGS).

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- we_onehot  input  16  write select from the decoder; bit k selects register k; all-zero means no write.
- wd  input  16  write data.
- rd_en  input  1  read request, sampled at the clock edge.
- ra1  input  4  read address, port 1.
- ra2  input  4  read address, port 2.
- rd1  output  16  registered read data, port 1.
- rd2  output  16  registered read data, port 2.
- rd_valid  output  1  high for one cycle when rd1/rd2 hold freshly fetched data.
- wr_err  output  1  one-cycle pulse: previous edge saw more than one bit set in we_onehot.
- wr_err_sticky  output  1  set on any wr_err; cleared only by rst.

Behaviour:
- Reset (rst=1 at a rising edge):
  - all 16 registers, rd1, rd2, rd_valid, wr_err and wr_err_sticky go to 0.
  - Any write or read presented in the same cycle is discarded.
  - rst dominates every other input, including mid-operation.
- Write, evaluated each edge with rst=0:
  - popcount(we_onehot)=0: no write, no error.
  - popcount=1 at bit k, k!=0: reg[k] <= wd.
  - popcount=1 at bit 0: write discarded, no error. R0 reads as 0 permanently.
  - popcount>=2: no register changes; wr_err=1 for the next cycle; wr_err_sticky=1.
- Read, latency 1 cycle:
  - rd_en=1 at edge N: at N+1, rd1=reg[ra1], rd2=reg[ra2], rd_valid=1.
  - rd_en=0: rd1/rd2 hold their last values; rd_valid=0.
  - ra1==ra2 is legal; both ports return the same data.
  - ra=0 always returns 0.
- Simultaneous write and read of the same register k (k!=0, valid one-hot, same edge): result depends on REGFILE_BYPASS_EN (see below).
- A read coinciding with an invalid multi-hot write returns the old value; the write never commits.
- No state machine beyond the registered read stage and the error flags. Throughput is one write and one dual read per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-edge write to register k forwards wd to any read port whose address is k, so rd at N+1 equals the new wd.
- Undefined: that read port returns the pre-write contents of reg[k]. The new value is visible to reads issued at N+1 onward.
- R0 is never bypassed in either configuration.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W, NREGS, ADDR_W, R0_IDX=0;
  - typedefs reg_data_t [15:0], reg_addr_t [3:0], reg_sel_t [15:0].
- One natural sub-module: onehot_encode_16.
  - Combinational; input reg_sel_t.
  - Outputs: index (4 bits), is_zero, is_onehot, is_multi.
  - Drives the write-commit and wr_err logic.

Test Plan:
- Reset then reads: assert rst 1 cycle; rd_en=1, ra1=5, ra2=15 -> next cycle rd1=0, rd2=0, rd_valid=1, wr_err_sticky=0.
- Write then read: we_onehot=16'h0008, wd=16'hBEEF; next cycle rd_en=1, ra1=3, ra2=0 -> rd1=16'hBEEF, rd2=16'h0000.
- R0 protection: we_onehot=16'h0001, wd=16'hFFFF; read ra1=0 -> rd1=0, wr_err=0.
- Multi-hot fault: reg4=16'h1234; we_onehot=16'h0030, wd=16'hAAAA -> wr_err=1 for exactly 1 cycle, wr_err_sticky stays 1; read ra1=4, ra2=5 -> 16'h1234 and prior reg5 value.
- Same-edge hazard: reg7=16'h0001; in one cycle we_onehot=16'h0080, wd=16'h0002, rd_en=1, ra1=7 -> rd1=16'h0002 with REGFILE_BYPASS_EN, 16'h0001 without.
- Reset mid-stream: write reg9=16'h5555 in the same cycle as rst=1; then read ra1=9 -> rd1=0.
